// File: rtl/vend_txn_controller_pkg.sv
// vend_pkg: shared types, default price table and selection helpers for the
// vending transaction controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_e;

  typedef logic [1:0] item_idx_t;
  typedef logic [3:0] credit_t;
  typedef credit_t [3:0] price_tbl_t;

  // Prices in 5-units, index 0 in the low nibble.
  localparam price_tbl_t DEFAULT_PRICE = {4'd6, 4'd5, 4'd4, 4'd3};

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic item_idx_t onehot_to_idx(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_txn_controller_timeout_timer.sv
// vend_timeout_timer: loadable down-counter; expired_o is high once TIMEOUT-1
// ticks have elapsed since the last load.
module vend_timeout_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic tick_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load wins over tick, saturate at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = W'(TIMEOUT - 1);
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= W'(TIMEOUT - 1);
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/vend_txn_controller.sv
// vend_txn_controller: select / collect / vend / change sequencer for the
// four-item coin vending machine. Define VEND_AUDIT_EN for audit counters.
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter int PRICE0     = int'(DEFAULT_PRICE[0]),
  parameter int PRICE1     = int'(DEFAULT_PRICE[1]),
  parameter int PRICE2     = int'(DEFAULT_PRICE[2]),
  parameter int PRICE3     = int'(DEFAULT_PRICE[3]),
  parameter int STOCK_INIT = 8,
  parameter int TIMEOUT    = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  item_sel,
  input  logic        item_valid,
  input  logic        five_in,
  input  logic        ten_in,
  input  logic        cancel,
  input  logic        disp_ack,
  input  logic        change_ack,
  output logic        disp_req,
  output logic [1:0]  disp_item,
  output logic        change_req,
  output logic        coin_reject,
  output logic [3:0]  credit,
  output logic [3:0]  sold_out,
  output logic        busy,
  output logic        sel_error
`ifdef VEND_AUDIT_EN
  ,
  output logic [15:0] sales_count,
  output logic [7:0]  refund_count
`endif
);

  localparam price_tbl_t PRICE_TBL = {credit_t'(PRICE3), credit_t'(PRICE2),
                                      credit_t'(PRICE1), credit_t'(PRICE0)};

  state_e            state_q, state_d;
  credit_t           credit_q, credit_d;
  credit_t           coin_add_s, credit_sum_s;
  item_idx_t         sel_q, sel_d, pick_s;
  logic [3:0][3:0]   stock_q, stock_d;
  logic [3:0]        sold_out_q, sold_out_d;
  logic              disp_req_q, disp_req_d;
  logic              change_req_q, change_req_d;
  logic              coin_reject_q, coin_reject_d;
  logic              sel_error_q, sel_error_d;
  logic              busy_q, busy_d;
  logic              coin_s, pick_ok_s;
  logic              timer_load_s, timer_expired_s;

  assign coin_s       = five_in | ten_in;
  assign coin_add_s   = ten_in ? 4'd2 : (five_in ? 4'd1 : 4'd0);
  assign credit_sum_s = credit_q + coin_add_s;
  assign pick_s       = onehot_to_idx(item_sel);
  assign pick_ok_s    = is_onehot4(item_sel) && (stock_q[pick_s] != 4'd0);

  vend_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load_i    (timer_load_s),
    .tick_i    (state_q == COLLECT),
    .expired_o (timer_expired_s)
  );

  // Next-state, credit/stock update and registered-output next values.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    sel_d         = sel_q;
    stock_d       = stock_q;
    coin_reject_d = 1'b0;
    sel_error_d   = 1'b0;
    timer_load_s  = 1'b0;
    sold_out_d    = 4'd0;

    case (state_q)
      IDLE: begin
        coin_reject_d = coin_s;
        if (item_valid && pick_ok_s) begin
          sel_d        = pick_s;
          credit_d     = 4'd0;
          timer_load_s = 1'b1;
          state_d      = COLLECT;
        end else if (item_valid) begin
          sel_error_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        // Simultaneous coins: the ten is kept, the five is diverted back.
        coin_reject_d = five_in & ten_in;
        credit_d      = credit_sum_s;
        timer_load_s  = coin_s;
        if (cancel) begin
          state_d = CHANGE;
        end else if (credit_sum_s >= PRICE_TBL[sel_q]) begin
          state_d = VEND;
        end else if (!coin_s && timer_expired_s) begin
          state_d = CHANGE;
        end else begin
          state_d = COLLECT;
        end
      end
      VEND: begin
        coin_reject_d = coin_s;
        if (disp_ack) begin
          credit_d       = credit_q - PRICE_TBL[sel_q];
          stock_d[sel_q] = stock_q[sel_q] - 4'd1;
          state_d        = CHANGE;
        end else begin
          state_d = VEND;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_s;
        if (credit_q == 4'd0) begin
          state_d = IDLE;
        end else if (change_ack) begin
          credit_d = credit_q - 4'd1;
          state_d  = (credit_q == 4'd1) ? IDLE : CHANGE;
        end else begin
          state_d = CHANGE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    disp_req_d   = (state_d == VEND);
    change_req_d = (state_d == CHANGE) && (credit_d != 4'd0);
    busy_d       = (state_d != IDLE);
    for (int n = 0; n < 4; n++) begin
      sold_out_d[n] = (stock_d[n] == 4'd0);
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      credit_q      <= 4'd0;
      sel_q         <= 2'd0;
      stock_q       <= {4{credit_t'(STOCK_INIT)}};
      sold_out_q    <= (STOCK_INIT == 0) ? 4'hF : 4'h0;
      disp_req_q    <= 1'b0;
      change_req_q  <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_error_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      sel_q         <= sel_d;
      stock_q       <= stock_d;
      sold_out_q    <= sold_out_d;
      disp_req_q    <= disp_req_d;
      change_req_q  <= change_req_d;
      coin_reject_q <= coin_reject_d;
      sel_error_q   <= sel_error_d;
      busy_q        <= busy_d;
    end
  end

  assign disp_req    = disp_req_q;
  assign disp_item   = sel_q;
  assign change_req  = change_req_q;
  assign coin_reject = coin_reject_q;
  assign credit      = credit_q;
  assign sold_out    = sold_out_q;
  assign busy        = busy_q;
  assign sel_error   = sel_error_q;

`ifdef VEND_AUDIT_EN
  logic [15:0] sales_q;
  logic [7:0]  refunds_q;

  // Audit counters: completed sales and cancel/timeout refunds, both wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      sales_q   <= 16'd0;
      refunds_q <= 8'd0;
    end else begin
      if ((state_q == VEND) && disp_ack) begin
        sales_q <= sales_q + 16'd1;
      end
      if ((state_q == COLLECT) && (state_d == CHANGE) && (credit_d != 4'd0)) begin
        refunds_q <= refunds_q + 8'd1;
      end
    end
  end

  assign sales_count  = sales_q;
  assign refund_count = refunds_q;
`endif

endmodule
